cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_pkg.sv | 27 ++
 rtl/cdb_rr_arb.sv | 51 +++++
 rtl/cdb_arbiter.sv | 114 +++++++++++
 tb/tb_cdb_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared CDB types: channel enum, broadcast packet, sizing constants.
// The CDB_RR_EN macro selects round-robin arbitration in cdb_rr_arb and cdb_arbiter.
package cdb_arbiter_pkg;

  localparam int NUM_FU    = 6;
  localparam int XLEN      = 32;
  localparam int PR_IDX_W  = 6;
  localparam int ROB_IDX_W = 5;
  localparam int FU_IDX_W  = 3;

  typedef enum logic [FU_IDX_W-1:0] {
    FU_ALU_1  = 3'd0,
    FU_ALU_2  = 3'd1,
    FU_ALU_3  = 3'd2,
    FU_MULT_1 = 3'd3,
    FU_MULT_2 = 3'd4,
    FU_BRANCH = 3'd5
  } fu_chan_e;

  typedef struct packed {
    logic [PR_IDX_W-1:0]  pr_idx;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [XLEN-1:0]      value;
    logic                 take_branch;
  } cdb_packet_t;

endpackage

// File: rtl/cdb_rr_arb.sv
// rtl/cdb_rr_arb.sv - single-grant arbiter over the occupied CDB slots.
// CDB_RR_EN: round-robin from i_ptr; otherwise fixed priority, highest index wins.
module cdb_rr_arb #(
  parameter int N     = 6,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx
);

`ifdef CDB_RR_EN
  int w_best;
  int w_dist;

  // Winner is the requester at the smallest forward distance from the pointer.
  always_comb begin
    o_idx   = '0;
    o_grant = '0;
    w_best  = N;
    w_dist  = 0;
    for (int i = 0; i < N; i++) begin
      w_dist = i - int'(i_ptr);
      if (w_dist < 0) w_dist = w_dist + N;
      if (i_req[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        o_idx  = IDX_W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      o_grant[i] = (|i_req) && (o_idx == IDX_W'(i));
    end
  end
`else
  logic w_unused_ptr;
  assign w_unused_ptr = ^i_ptr;

  always_comb begin
    o_idx   = '0;
    o_grant = '0;
    for (int i = 0; i < N; i++) begin
      if (i_req[i]) o_idx = IDX_W'(i);
    end
    for (int i = 0; i < N; i++) begin
      o_grant[i] = (|i_req) && (o_idx == IDX_W'(i));
    end
  end
`endif

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - per-channel completion slots arbitrated onto one registered CDB broadcast.
// CDB_RR_EN: adds the round-robin pointer register; default build is fixed priority.
module cdb_arbiter #(
  parameter int NUM_FU    = cdb_arbiter_pkg::NUM_FU,
  parameter int XLEN      = cdb_arbiter_pkg::XLEN,
  parameter int PR_IDX_W  = cdb_arbiter_pkg::PR_IDX_W,
  parameter int ROB_IDX_W = cdb_arbiter_pkg::ROB_IDX_W
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_FU-1:0]             fu_valid,
  output logic [NUM_FU-1:0]             fu_ready,
  input  logic [NUM_FU*PR_IDX_W-1:0]    fu_pr_idx,
  input  logic [NUM_FU*ROB_IDX_W-1:0]   fu_rob_idx,
  input  logic [NUM_FU*XLEN-1:0]        fu_value,
  input  logic [NUM_FU-1:0]             fu_take_branch,
  input  logic                          squash,
  output logic                          cdb_valid,
  output logic [PR_IDX_W-1:0]           cdb_pr_idx,
  output logic [ROB_IDX_W-1:0]          cdb_rob_idx,
  output logic [XLEN-1:0]               cdb_value,
  output logic                          cdb_take_branch,
  output logic [2:0]                    cdb_src
);
  import cdb_arbiter_pkg::*;

  localparam int IDX_W = 3;

  logic [NUM_FU-1:0] r_slot_valid;
  cdb_packet_t       r_slot_pkt [NUM_FU];
  cdb_packet_t       w_in_pkt   [NUM_FU];
  logic [NUM_FU-1:0] w_grant;
  logic [NUM_FU-1:0] w_capture;
  logic [IDX_W-1:0]  w_grant_idx;
  logic [IDX_W-1:0]  w_ptr;
  logic              w_any;

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      w_in_pkt[i].pr_idx      = fu_pr_idx[i*PR_IDX_W +: PR_IDX_W];
      w_in_pkt[i].rob_idx     = fu_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
      w_in_pkt[i].value       = fu_value[i*XLEN +: XLEN];
      w_in_pkt[i].take_branch = fu_take_branch[i];
    end
  end

  assign w_any     = |r_slot_valid;
  // A slot being drained this edge can take a new packet at the same edge.
  assign fu_ready  = ~r_slot_valid | w_grant | {NUM_FU{squash}};
  assign w_capture = fu_valid & fu_ready & ~{NUM_FU{squash}};

`ifdef CDB_RR_EN
  logic [IDX_W-1:0] r_ptr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (!squash && w_any) begin
      r_ptr <= (w_grant_idx == IDX_W'(NUM_FU-1)) ? '0 : w_grant_idx + 1'b1;
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  cdb_rr_arb #(
    .N     (NUM_FU),
    .IDX_W (IDX_W)
  ) u_arb (
    .i_req   (r_slot_valid),
    .i_ptr   (w_ptr),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_slot_valid <= '0;
      for (int i = 0; i < NUM_FU; i++) r_slot_pkt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (squash)            r_slot_valid[i] <= 1'b0;
        else if (w_capture[i]) r_slot_valid[i] <= 1'b1;
        else if (w_grant[i])   r_slot_valid[i] <= 1'b0;
        if (w_capture[i])      r_slot_pkt[i]   <= w_in_pkt[i];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cdb_valid       <= 1'b0;
      cdb_pr_idx      <= '0;
      cdb_rob_idx     <= '0;
      cdb_value       <= '0;
      cdb_take_branch <= 1'b0;
      cdb_src         <= '0;
    end else if (squash) begin
      cdb_valid <= 1'b0;
    end else begin
      cdb_valid <= w_any;
      if (w_any) begin
        cdb_pr_idx      <= r_slot_pkt[w_grant_idx].pr_idx;
        cdb_rob_idx     <= r_slot_pkt[w_grant_idx].rob_idx;
        cdb_value       <= r_slot_pkt[w_grant_idx].value;
        cdb_take_branch <= r_slot_pkt[w_grant_idx].take_branch;
        cdb_src         <= w_grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed and random checks of cdb_arbiter against a slot-level reference model.
module tb_cdb_arbiter;
  localparam int NF = 6;
  localparam int XL = 32;
  localparam int PW = 6;
  localparam int RW = 5;

  logic             clock = 1'b0;
  logic             reset;
  logic [NF-1:0]    fu_valid;
  logic [NF-1:0]    fu_ready;
  logic [NF*PW-1:0] fu_pr_idx;
  logic [NF*RW-1:0] fu_rob_idx;
  logic [NF*XL-1:0] fu_value;
  logic [NF-1:0]    fu_take_branch;
  logic             squash;
  logic             cdb_valid;
  logic [PW-1:0]    cdb_pr_idx;
  logic [RW-1:0]    cdb_rob_idx;
  logic [XL-1:0]    cdb_value;
  logic             cdb_take_branch;
  logic [2:0]       cdb_src;

  always #5 clock = ~clock;

  cdb_arbiter dut (
    .clock(clock), .reset(reset),
    .fu_valid(fu_valid), .fu_ready(fu_ready),
    .fu_pr_idx(fu_pr_idx), .fu_rob_idx(fu_rob_idx), .fu_value(fu_value),
    .fu_take_branch(fu_take_branch), .squash(squash),
    .cdb_valid(cdb_valid), .cdb_pr_idx(cdb_pr_idx), .cdb_rob_idx(cdb_rob_idx),
    .cdb_value(cdb_value), .cdb_take_branch(cdb_take_branch), .cdb_src(cdb_src)
  );

  bit            m_v   [NF];
  logic [PW-1:0] m_pr  [NF];
  logic [RW-1:0] m_rob [NF];
  logic [XL-1:0] m_val [NF];
  bit            m_tb  [NF];
  int            m_ptr;
  bit            mc_v;
  logic [PW-1:0] mc_pr;
  logic [RW-1:0] mc_rob;
  logic [XL-1:0] mc_val;
  bit            mc_tb;
  logic [2:0]    mc_src;
  int            m_acc;

  int            bcast_src [$];
  int            bcast_tag [$];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
`ifdef CDB_RR_EN
    for (int off = 0; off < NF; off++) begin
      if (m_v[(m_ptr + off) % NF]) return (m_ptr + off) % NF;
    end
`else
    for (int c = NF - 1; c >= 0; c--) begin
      if (m_v[c]) return c;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NF; i++) m_v[i] = 0;
    m_ptr = 0; mc_v = 0; mc_pr = '0; mc_rob = '0; mc_val = '0; mc_tb = 0; mc_src = '0;
  endtask

  task automatic set_pkt(input int ch, input int pr, input int rob, input logic [XL-1:0] val, input bit tb);
    fu_pr_idx[ch*PW +: PW]  = PW'(pr);
    fu_rob_idx[ch*RW +: RW] = RW'(rob);
    fu_value[ch*XL +: XL]   = val;
    fu_take_branch[ch]      = tb;
  endtask

  task automatic rand_pkts();
    for (int ch = 0; ch < NF; ch++)
      set_pkt(ch, int'($urandom_range(63)), int'($urandom_range(31)), $urandom, bit'($urandom_range(1)));
  endtask

  // Called at a negedge with inputs applied; returns at the following negedge.
  task automatic cycle();
    int g;
    logic [NF-1:0] er;
    #1;
    g = pick();
    for (int i = 0; i < NF; i++) er[i] = !m_v[i] || (g == i) || squash;
    chk("fu_ready", fu_ready, er);
    @(posedge clock);
    if (squash) begin
      for (int i = 0; i < NF; i++) m_v[i] = 0;
      mc_v = 0;
    end else begin
      mc_v = (g >= 0);
      if (g >= 0) begin
        mc_pr = m_pr[g]; mc_rob = m_rob[g]; mc_val = m_val[g]; mc_tb = m_tb[g];
        mc_src = 3'(g);
`ifdef CDB_RR_EN
        m_ptr = (g + 1) % NF;
`endif
      end
      for (int i = 0; i < NF; i++) begin
        if (fu_valid[i] && er[i]) begin
          m_v[i] = 1; m_acc++;
          m_pr[i]  = fu_pr_idx[i*PW +: PW];
          m_rob[i] = fu_rob_idx[i*RW +: RW];
          m_val[i] = fu_value[i*XL +: XL];
          m_tb[i]  = fu_take_branch[i];
        end else if (g == i) begin
          m_v[i] = 0;
        end
      end
    end
    #1;
    chk("cdb_valid", cdb_valid, mc_v);
    if (mc_v) begin
      chk("cdb_pr_idx", cdb_pr_idx, mc_pr);
      chk("cdb_rob_idx", cdb_rob_idx, mc_rob);
      chk("cdb_value", cdb_value, mc_val);
      chk("cdb_take_branch", cdb_take_branch, mc_tb);
      chk("cdb_src", cdb_src, mc_src);
    end
    if (cdb_valid === 1'b1) begin
      bcast_src.push_back(int'(cdb_src));
      bcast_tag.push_back(int'(cdb_pr_idx));
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; squash = 1'b0; fu_valid = '0;
    fu_pr_idx = '0; fu_rob_idx = '0; fu_value = '0; fu_take_branch = '0;
    model_reset();
    m_acc = 0;
    #2;
    chk("rst_ready", fu_ready, 6'h3f);
    chk("rst_cdb_valid", cdb_valid, 0);
    chk("rst_cdb_pr", cdb_pr_idx, 0);
    chk("rst_cdb_rob", cdb_rob_idx, 0);
    chk("rst_cdb_value", cdb_value, 0);
    chk("rst_cdb_tb", cdb_take_branch, 0);
    chk("rst_cdb_src", cdb_src, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // single ALU_1 result
    set_pkt(0, 7, 3, 32'h10, 0);
    fu_valid = 6'b000001;
    #1 chk("req020_ready0", fu_ready[0], 1);
    cycle();
    fu_valid = '0;
    cycle();
    chk("req020_valid", cdb_valid, 1);
    chk("req020_pr", cdb_pr_idx, 7);
    chk("req020_value", cdb_value, 32'h10);
    chk("req020_src", cdb_src, 0);
    cycle();
    chk("req020_done", cdb_valid, 0);

    // all six channels in one cycle
    do_reset();
    bcast_src.delete(); bcast_tag.delete();
    for (int ch = 0; ch < NF; ch++) set_pkt(ch, ch + 1, ch, 100 + ch, ch == 5);
    fu_valid = 6'h3f;
    cycle();
    fu_valid = '0;
    repeat (8) cycle();
    chk("req021_count", bcast_src.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < bcast_src.size()) begin
`ifdef CDB_RR_EN
        chk("req021_order", bcast_src[k], k);
        chk("req021_tag", bcast_tag[k], k + 1);
`else
        chk("req021_order", bcast_src[k], 5 - k);
        chk("req021_tag", bcast_tag[k], 6 - k);
`endif
      end
    end

    // ALU_2 streaming back to back
    bcast_src.delete(); bcast_tag.delete();
    for (int k = 0; k < 10; k++) begin
      set_pkt(1, 20 + k, k, 32'h200 + k, 0);
      fu_valid = 6'b000010;
      if (k > 0) chk("req022_ready1", fu_ready[1], 1);
      cycle();
    end
    fu_valid = '0;
    repeat (3) cycle();
    chk("req022_count", bcast_tag.size(), 10);
    for (int k = 0; k < 10; k++)
      if (k < bcast_tag.size()) chk("req022_tag", bcast_tag[k], 20 + k);

    // saturate all slots
    bcast_src.delete(); bcast_tag.delete();
    m_acc = 0;
    for (int k = 0; k < 20; k++) begin
      rand_pkts();
      fu_valid = 6'h3f;
      if (k > 0) chk("req023_onehot", $onehot(fu_ready), 1);
      cycle();
    end
    fu_valid = '0;
    repeat (8) cycle();
    chk("req023_acc_eq_bcast", bcast_tag.size(), m_acc);

    // squash with three held slots
    set_pkt(0, 40, 1, 32'h40, 0);
    set_pkt(2, 41, 2, 32'h41, 0);
    set_pkt(4, 42, 3, 32'h42, 0);
    fu_valid = 6'b010101;
    cycle();
    bcast_src.delete(); bcast_tag.delete();
    fu_valid = '0;
    squash = 1'b1;
    cycle();
    squash = 1'b0;
    chk("req024_cdb_valid", cdb_valid, 0);
    set_pkt(3, 50, 9, 32'h50, 1);
    fu_valid = 6'b001000;
    cycle();
    fu_valid = '0;
    repeat (4) cycle();
    chk("req024_count", bcast_tag.size(), 1);
    if (bcast_tag.size() > 0) begin
      chk("req024_tag", bcast_tag[0], 50);
      chk("req024_src", bcast_src[0], 3);
    end

    // asynchronous reset with slots held
    rand_pkts();
    fu_valid = 6'h3f;
    cycle();
    fu_valid = '0;
    cycle();
    chk("req025_pre_valid", cdb_valid, 1);
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("req025_async_valid", cdb_valid, 0);
    chk("req025_ready_ones", fu_ready, 6'h3f);
    @(negedge clock);
    reset = 1'b0;
    bcast_src.delete(); bcast_tag.delete();
    repeat (6) cycle();
    chk("req025_no_bcast", bcast_tag.size(), 0);

    // random traffic with occasional squash
    for (int k = 0; k < 400; k++) begin
      rand_pkts();
      fu_valid = NF'($urandom);
      squash = ($urandom_range(19) == 0);
      cycle();
    end
    squash = 1'b0;
    fu_valid = '0;
    repeat (8) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
